// File: rtl/wb_regfile.sv
// Write-back stage and 32x64 integer register file with two decode read ports.
// Read ports see same-cycle writes through a bypass; wb_count tracks committed writes.
module wb_regfile #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Regwrite,
  input  logic            MemtoReg,
  input  logic [XLEN-1:0] Read_Data,
  input  logic [XLEN-1:0] Result,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] ReadData1,
  output logic [XLEN-1:0] ReadData2,
  output logic [XLEN-1:0] WriteData,
  output logic            wb_valid,
  output logic [CNTW-1:0] wb_count
);

  logic [XLEN-1:0] regs [NREG];
  logic [XLEN-1:0] sel_data;

  always_comb begin
    sel_data  = MemtoReg ? Read_Data : Result;
    WriteData = reset ? '0 : sel_data;
    wb_valid  = ~reset & Regwrite & (rd != 5'd0);
  end

  // x0 is hard-wired to zero, so it never takes the bypass path either
  always_comb begin
    ReadData1 = '0;
    if (rs1 != 5'd0) begin
      ReadData1 = (wb_valid && (rs1 == rd)) ? WriteData : regs[rs1];
    end
  end

  always_comb begin
    ReadData2 = '0;
    if (rs2 != 5'd0) begin
      ReadData2 = (wb_valid && (rs2 == rd)) ? WriteData : regs[rs2];
    end
  end

  // Register write: commits on the edge, so the array holds it from the next cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid) begin
      regs[rd] <= WriteData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_count <= '0;
    end else if (wb_valid) begin
      wb_count <= wb_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed + randomized bench for wb_regfile against an array-based reference model.
// A second instance built with CNTW=4 shares the stimulus to exercise counter wrap.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        Regwrite, MemtoReg;
  logic [63:0] Read_Data, Result;
  logic [4:0]  rd, rs1, rs2;
  logic [63:0] ReadData1, ReadData2, WriteData;
  logic        wb_valid;
  logic [31:0] wb_count;
  logic [63:0] r4_1, r4_2, wd4;
  logic        wv4;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  logic [63:0] mdl [32];
  int unsigned mcount;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset(reset), .Regwrite(Regwrite), .MemtoReg(MemtoReg),
    .Read_Data(Read_Data), .Result(Result), .rd(rd), .rs1(rs1), .rs2(rs2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .WriteData(WriteData),
    .wb_valid(wb_valid), .wb_count(wb_count)
  );

  wb_regfile #(.XLEN(64), .NREG(32), .CNTW(4)) dut4 (
    .clk(clk), .reset(reset), .Regwrite(Regwrite), .MemtoReg(MemtoReg),
    .Read_Data(Read_Data), .Result(Result), .rd(rd), .rs1(rs1), .rs2(rs2),
    .ReadData1(r4_1), .ReadData2(r4_2), .WriteData(wd4),
    .wb_valid(wv4), .wb_count(cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_wv();
    return !reset && Regwrite && (rd != 5'd0);
  endfunction

  function automatic logic [63:0] model_wd();
    if (reset) return 64'd0;
    return MemtoReg ? Read_Data : Result;
  endfunction

  // Architectural view of a read port: x0 is zero, a same-cycle write wins, else the array.
  function automatic logic [63:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 64'd0;
    if (model_wv() && idx == rd) return model_wd();
    return mdl[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
    mcount = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".rd1"},   ReadData1, model_read(rs1));
    chk({tag, ".rd2"},   ReadData2, model_read(rs2));
    chk({tag, ".wdata"}, WriteData, model_wd());
    chk({tag, ".wvld"},  {63'd0, wb_valid}, {63'd0, model_wv()});
    chk({tag, ".cnt"},   {32'd0, wb_count}, {32'd0, mcount});
    chk({tag, ".rd1_c4"}, r4_1, model_read(rs1));
    chk({tag, ".cnt_c4"}, {60'd0, cnt4}, {60'd0, mcount[3:0]});
  endtask

  // Drive one MEM/WB beat, check combinational outputs mid-cycle, then clock it in.
  task automatic apply(input string tag, input logic rw, input logic mtr,
                       input logic [63:0] ld, input logic [63:0] res,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    Regwrite = rw; MemtoReg = mtr; Read_Data = ld; Result = res;
    rd = d; rs1 = s1; rs2 = s2;
    #1;
    check_outputs(tag);
    @(posedge clk);
    if (model_wv()) begin
      mdl[rd] = model_wd();
      mcount++;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    Regwrite = 1'b0; MemtoReg = 1'b0; Read_Data = '0; Result = '0;
    rd = '0; rs1 = '0; rs2 = '0;
    model_clear();

    // 1: writes ignored while in reset
    @(posedge clk); #1;
    apply("rst_wr", 1'b1, 1'b0, 64'd0, 64'hAAAA, 5'd5, 5'd5, 5'd31);
    reset = 1'b0;
    apply("post_rst", 1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd5, 5'd31);
    chk("t1.rd1_zero", ReadData1, 64'd0);
    chk("t1.cnt_zero", {32'd0, wb_count}, 64'd0);

    // 2: same-cycle bypass then stored value
    Regwrite = 1'b1; MemtoReg = 1'b0; Result = 64'h1234; rd = 5'd7; rs1 = 5'd7; rs2 = 5'd0;
    #1;
    chk("t2.bypass", ReadData1, 64'h1234);
    apply("t2.wr", 1'b1, 1'b0, 64'd0, 64'h1234, 5'd7, 5'd7, 5'd0);
    apply("t2.rdbk", 1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd7, 5'd0);
    chk("t2.reg7", ReadData1, 64'h1234);
    chk("t2.cnt1", {32'd0, wb_count}, 64'd1);

    // 3: load data selected
    apply("t3.wr", 1'b1, 1'b1, 64'hDEADBEEF_00000001, 64'h5, 5'd3, 5'd0, 5'd0);
    apply("t3.rdbk", 1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd3, 5'd3);
    chk("t3.reg3", ReadData2, 64'hDEADBEEF_00000001);

    // 4: x0 write discarded
    apply("t4.x0", 1'b1, 1'b0, 64'd0, 64'hFF, 5'd0, 5'd0, 5'd0);
    chk("t4.cnt", {32'd0, wb_count}, 64'd2);

    // 5: back-to-back writes, then async reset mid-cycle
    apply("t5.a", 1'b1, 1'b0, 64'd0, 64'h11, 5'd9, 5'd9, 5'd9);
    apply("t5.b", 1'b1, 1'b0, 64'd0, 64'h22, 5'd9, 5'd9, 5'd9);
    apply("t5.c", 1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd9, 5'd9);
    chk("t5.cnt4", {32'd0, wb_count}, 64'd4);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    chk("t5.async_reg9", ReadData1, 64'd0);
    chk("t5.async_cnt", {32'd0, wb_count}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 6: narrow counter wraps after 16 writes
    for (int i = 0; i < 15; i++) begin
      apply("t6.fill", 1'b1, 1'b0, 64'd0, 64'(i), 5'(i + 1), 5'(i + 1), 5'd0);
    end
    chk("t6.cnt15", {60'd0, cnt4}, 64'd15);
    apply("t6.last", 1'b1, 1'b0, 64'd0, 64'h77, 5'd20, 5'd20, 5'd1);
    chk("t6.wrap", {60'd0, cnt4}, 64'd0);
    chk("t6.wide", {32'd0, wb_count}, 64'd16);

    // bubble: all-zero MEM/WB inputs
    apply("bubble", 1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd20, 5'd1);

    // randomized traffic with occasional async reset
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 60) == 0) begin
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        check_outputs("rnd.rst");
        @(posedge clk); #1;
        reset = 1'b0;
      end
      apply("rnd", ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
            {$urandom, $urandom}, {$urandom, $urandom},
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the pipeline: consumes the MEM/WB stage outputs and performs the register write.
- Selects the write-back value (load data vs. ALU result), writes the 32x64 integer register file, and serves two decode-stage read ports.
- Read ports have same-cycle write-through bypass, so ID sees a value written in WB in the same cycle.
- Keeps a retired-write counter for debug/perf.

Parameters:
XLEN, 64, data width of registers and write-back values
NREG, 32, number of architectural registers (index width 5)
CNTW, 32, width of write-back counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
Regwrite  input  1  write enable from MEM/WB register
MemtoReg  input  1  1: write Read_Data, 0: write Result
Read_Data  input  XLEN  load data from MEM/WB
Result  input  XLEN  ALU result from MEM/WB
rd  input  5  destination register index
rs1  input  5  read port 1 index (ID stage)
rs2  input  5  read port 2 index (ID stage)
ReadData1  output  XLEN  value of rs1
ReadData2  output  XLEN  value of rs2
WriteData  output  XLEN  selected write-back value (to forwarding unit)
wb_valid  output  1  Regwrite & (rd != 0), current-cycle write qualifier
wb_count  output  CNTW  number of committed writes to non-zero registers since reset

Behaviour:
- Reset (async, active-high): all 32 registers <= 0 and wb_count <= 0, applied immediately without waiting for a clock edge. While reset is high, no write occurs. ReadData1/2 and WriteData read as 0 (registers are zero; WriteData is forced to 0 and wb_valid to 0 while reset is high).
- WriteData (combinational) = MemtoReg ? Read_Data : Result.
- Write: on posedge clk with reset low, if Regwrite=1 and rd!=0, then reg[rd] <= WriteData. Latency is one edge: the stored value is visible from the register array after that edge.
- x0: writes with rd=0 are discarded. Register 0 always reads 0, including through the bypass.
- Reads (combinational, before any bypass):
  - ReadData1 = (rs1==0) ? 0 : reg[rs1].
  - ReadData2 = (rs2==0) ? 0 : reg[rs2].
- Bypass: if wb_valid and rs1==rd, ReadData1 = WriteData. Same rule for rs2 and ReadData2. Both ports may bypass simultaneously (rs1==rs2==rd).
- wb_count: increments by 1 on each edge where a write is committed (wb_valid=1 and reset low). It wraps modulo 2^CNTW. Writes to x0 and cycles with Regwrite=0 do not count.
- Bubble: all-zero MEM/WB inputs (as produced by a MEM/WB reset or flush) give Regwrite=0, so no write, no count, and no bypass.
- Reset asserted mid-stream: a pending write in that cycle is lost. After reset deasserts, the first edge with Regwrite=1 writes normally.
- No X-propagation on the read ports: indices are 5 bits, so all 32 entries are defined after reset.

Test Plan:
1. Assert reset, write attempts ignored; deassert, read rs1=5, rs2=31 -> both 0, wb_count=0.
2. Regwrite=1, MemtoReg=0, Result=0x1234, rd=7, rs1=7 in the same cycle -> ReadData1=0x1234 pre-edge (bypass), WriteData=0x1234. Next cycle with Regwrite=0 -> reg7 reads 0x1234 and wb_count=1.
3. Regwrite=1, MemtoReg=1, Read_Data=0xDEADBEEF_00000001, Result=0x5, rd=3 -> reg3=0xDEADBEEF_00000001 (Result not selected).
4. Regwrite=1, rd=0, Result=0xFF, rs1=rs2=0 -> ReadData1=ReadData2=0, wb_valid=0, wb_count unchanged.
5. Back-to-back writes rd=9 with 0x11 then 0x22, rs1=rs2=9 -> both ports return 0x11 in the first cycle and 0x22 in the second (bypass each cycle), wb_count +2. Then assert reset asynchronously mid-cycle -> reg9 reads 0 immediately and wb_count=0.
6. Preload wb_count to 2^CNTW-1 (CNTW=4 build, 15 writes), one more write -> wb_count wraps to 0.
